// File: rtl/stereo_mpx_decoder.sv
// Loopback FM stereo MPX decoder: 4:1 boxcar decimation of the composite
// sum plus synchronous 38 kHz product detection, rebuilding L/R at 48 kHz.
module stereo_mpx_decoder #(
    parameter int unsigned SUM_SHIFT  = 2,
    parameter int unsigned DIFF_SHIFT = 8,
    parameter int unsigned SLIP_W     = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     clken48kHz,
    input  logic                     clken192kHz,
    input  logic signed [19:0]       MPXin,
    input  logic signed [7:0]        carrier38,
    output logic signed [17:0]       LpR_est,
    output logic signed [17:0]       LmR_est,
    output logic signed [17:0]       LEFTout,
    output logic signed [17:0]       RIGHTout,
    output logic                     out_valid,
    output logic                     locked,
    output logic [SLIP_W-1:0]        slip_count
);

    localparam int unsigned PROD_W  = 28;
    localparam int unsigned ACC_S_W = 22;
    localparam int unsigned ACC_D_W = 30;
    localparam int unsigned OUT_W   = 18;
    localparam int unsigned MID_W   = 19;
    localparam int unsigned CNT_W   = 3;

    localparam logic signed [ACC_D_W-1:0] C_SAT_MAX = ACC_D_W'(131071);
    localparam logic signed [ACC_D_W-1:0] C_SAT_MIN = ACC_D_W'(-131072);
    localparam logic [CNT_W-1:0]          C_CNT_FULL  = CNT_W'(4);
    localparam logic [CNT_W-1:0]          C_CNT_MAX   = CNT_W'(7);

    typedef enum logic {
        S_SYNC = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t                      r_state;
    logic                        r_locked;
    logic signed [ACC_S_W-1:0]   r_acc_s;
    logic signed [ACC_D_W-1:0]   r_acc_d;
    logic [CNT_W-1:0]            r_cnt;
    logic signed [ACC_S_W-1:0]   r_dump_s;
    logic signed [ACC_D_W-1:0]   r_dump_d;
    logic                        r_pending;
    logic                        r_out_valid;
    logic [SLIP_W-1:0]           r_slip;
    logic signed [OUT_W-1:0]     r_lpr;
    logic signed [OUT_W-1:0]     r_lmr;
    logic signed [OUT_W-1:0]     r_left;
    logic signed [OUT_W-1:0]     r_right;

    logic signed [PROD_W-1:0]    w_prod;
    logic signed [ACC_S_W-1:0]   w_sample_s;
    logic signed [ACC_D_W-1:0]   w_sample_d;
    logic signed [ACC_S_W-1:0]   w_sh_s;
    logic signed [ACC_D_W-1:0]   w_sh_d;
    logic signed [OUT_W-1:0]     w_lpr;
    logic signed [OUT_W-1:0]     w_lmr;
    logic signed [MID_W-1:0]     w_sum;
    logic signed [MID_W-1:0]     w_dif;
    logic signed [OUT_W-1:0]     w_left;
    logic signed [OUT_W-1:0]     w_right;

    // Clamp a wide signed value into the 18-bit output range.
    function automatic logic signed [OUT_W-1:0] sat18(input logic signed [ACC_D_W-1:0] x);
        if (x > C_SAT_MAX) begin
            sat18 = OUT_W'(C_SAT_MAX);
        end else if (x < C_SAT_MIN) begin
            sat18 = OUT_W'(C_SAT_MIN);
        end else begin
            sat18 = OUT_W'(x);
        end
    endfunction

    // Per-sample contributions to the sum and product accumulators.
    assign w_prod     = PROD_W'(MPXin) * PROD_W'(carrier38);
    assign w_sample_s = ACC_S_W'(MPXin);
    assign w_sample_d = ACC_D_W'(w_prod);

    // Stage-2 reconstruction from the captured frame; the 19-bit half-sum
    // always fits in 18 bits, so no clamp is needed after the halving shift.
    assign w_sh_s  = r_dump_s >>> SUM_SHIFT;
    assign w_sh_d  = r_dump_d >>> DIFF_SHIFT;
    assign w_lpr   = sat18(ACC_D_W'(w_sh_s));
    assign w_lmr   = sat18(w_sh_d);
    assign w_sum   = MID_W'(w_lpr) + MID_W'(w_lmr);
    assign w_dif   = MID_W'(w_lpr) - MID_W'(w_lmr);
    assign w_left  = OUT_W'(w_sum >>> 1);
    assign w_right = OUT_W'(w_dif >>> 1);

    // Frame FSM, accumulators, slip counter and registered output stage.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= S_SYNC;
            r_locked    <= 1'b0;
            r_acc_s     <= '0;
            r_acc_d     <= '0;
            r_cnt       <= '0;
            r_dump_s    <= '0;
            r_dump_d    <= '0;
            r_pending   <= 1'b0;
            r_out_valid <= 1'b0;
            r_slip      <= '0;
            r_lpr       <= '0;
            r_lmr       <= '0;
            r_left      <= '0;
            r_right     <= '0;
        end else begin
            r_pending   <= 1'b0;
            r_out_valid <= 1'b0;

            if (r_pending) begin
                r_lpr       <= w_lpr;
                r_lmr       <= w_lmr;
                r_left      <= w_left;
                r_right     <= w_right;
                r_out_valid <= 1'b1;
            end

            case (r_state)
                S_SYNC: begin
                    if (clken48kHz) begin
                        r_acc_s  <= clken192kHz ? w_sample_s : '0;
                        r_acc_d  <= clken192kHz ? w_sample_d : '0;
                        r_cnt    <= clken192kHz ? CNT_W'(1) : '0;
                        r_state  <= S_RUN;
                        r_locked <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (clken48kHz) begin
                        if (r_cnt == C_CNT_FULL) begin
                            r_dump_s  <= r_acc_s;
                            r_dump_d  <= r_acc_d;
                            r_pending <= 1'b1;
                        end else if (r_slip != '1) begin
                            r_slip <= r_slip + SLIP_W'(1);
                        end
                        // a coincident sample opens the new frame
                        r_acc_s <= clken192kHz ? w_sample_s : '0;
                        r_acc_d <= clken192kHz ? w_sample_d : '0;
                        r_cnt   <= clken192kHz ? CNT_W'(1) : '0;
                    end else if (clken192kHz) begin
                        r_acc_s <= r_acc_s + w_sample_s;
                        r_acc_d <= r_acc_d + w_sample_d;
                        if (r_cnt != C_CNT_MAX) begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                end
                default: r_state <= S_SYNC;
            endcase
        end
    end

    assign LpR_est    = r_lpr;
    assign LmR_est    = r_lmr;
    assign LEFTout    = r_left;
    assign RIGHTout   = r_right;
    assign out_valid  = r_out_valid;
    assign locked     = r_locked;
    assign slip_count = r_slip;

endmodule

// File: tb/tb_stereo_mpx_decoder.sv
// Scoreboard bench for stereo_mpx_decoder: directed frames with
// hand-computed expected outputs, checked by an independent monitor.
`timescale 1ns/1ps
module tb_stereo_mpx_decoder;

    logic               clock = 1'b0;
    logic               reset = 1'b1;
    logic               clken48kHz = 1'b0;
    logic               clken192kHz = 1'b0;
    logic signed [19:0] MPXin = '0;
    logic signed [7:0]  carrier38 = '0;
    logic signed [17:0] LpR_est;
    logic signed [17:0] LmR_est;
    logic signed [17:0] LEFTout;
    logic signed [17:0] RIGHTout;
    logic               out_valid;
    logic               locked;
    logic [7:0]         slip_count;

    typedef struct {
        int lpr;
        int lmr;
        int l;
        int r;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    logic signed [19:0] fm [4];
    logic signed [7:0]  fc [4];

    stereo_mpx_decoder #(.SUM_SHIFT(2), .DIFF_SHIFT(8), .SLIP_W(8)) dut (
        .clock       (clock),
        .reset       (reset),
        .clken48kHz  (clken48kHz),
        .clken192kHz (clken192kHz),
        .MPXin       (MPXin),
        .carrier38   (carrier38),
        .LpR_est     (LpR_est),
        .LmR_est     (LmR_est),
        .LEFTout     (LEFTout),
        .RIGHTout    (RIGHTout),
        .out_valid   (out_valid),
        .locked      (locked),
        .slip_count  (slip_count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic expect_out(input int lpr, input int lmr, input int l, input int r);
        exp_t e;
        e.lpr = lpr; e.lmr = lmr; e.l = l; e.r = r;
        q.push_back(e);
    endtask

    task automatic set_fm(input int a, input int b, input int c, input int d);
        fm[0] = 20'(a); fm[1] = 20'(b); fm[2] = 20'(c); fm[3] = 20'(d);
    endtask

    task automatic set_fc(input int a, input int b, input int c, input int d);
        fc[0] = 8'(a); fc[1] = 8'(b); fc[2] = 8'(c); fc[3] = 8'(d);
    endtask

    task automatic cyc(input bit s48, input bit s192,
                       input logic signed [19:0] m, input logic signed [7:0] c);
        clken48kHz  = s48;
        clken192kHz = s192;
        MPXin       = m;
        carrier38   = c;
        @(posedge clock);
        #1;
        clken48kHz  = 1'b0;
        clken192kHz = 1'b0;
    endtask

    // 48 kHz strobe (optionally with the first sample) followed by the rest of n samples.
    task automatic run_frame(input int n, input bit coin);
        cyc(1'b1, coin, fm[0], fc[0]);
        cyc(1'b0, 1'b0, '0, '0);
        for (int i = (coin ? 1 : 0); i < n; i++) begin
            cyc(1'b0, 1'b1, fm[i % 4], fc[i % 4]);
            cyc(1'b0, 1'b0, '0, '0);
        end
    endtask

    // Monitor: every out_valid pulse must match the oldest expected result.
    always @(negedge clock) begin
        if (out_valid !== 1'b0) begin
            if (q.size() == 0) begin
                chk("unexpected_out_valid", 1, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("LpR_est",  int'(LpR_est),  e.lpr);
                chk("LmR_est",  int'(LmR_est),  e.lmr);
                chk("LEFTout",  int'(LEFTout),  e.l);
                chk("RIGHTout", int'(RIGHTout), e.r);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset held with both strobes active
        reset = 1'b1;
        repeat (5) cyc(1'b1, 1'b1, 20'sd4000, 8'sd5);
        @(negedge clock);
        chk("rst_LpR",    int'(LpR_est), 0);
        chk("rst_LmR",    int'(LmR_est), 0);
        chk("rst_LEFT",   int'(LEFTout), 0);
        chk("rst_RIGHT",  int'(RIGHTout), 0);
        chk("rst_locked", int'(locked), 0);
        chk("rst_slip",   int'(slip_count), 0);
        chk("rst_valid",  int'(out_valid), 0);
        reset = 1'b0;

        // samples before the first frame strobe are ignored
        cyc(1'b0, 1'b1, 20'sd9999, 8'sd0);
        @(negedge clock);
        chk("sync_locked", int'(locked), 0);

        // DC L+R
        set_fm(4000, 4000, 4000, 4000);
        set_fc(0, 0, 0, 0);
        run_frame(4, 1'b0);
        @(negedge clock);
        chk("run_locked", int'(locked), 1);
        repeat (3) begin
            expect_out(4000, 0, 2000, 2000);
            run_frame(4, 1'b0);
        end
        expect_out(4000, 0, 2000, 2000);

        // small L-R, positive then negative (floor shift)
        set_fm(1000, -1000, 1000, -1000);
        set_fc(127, -127, 127, -127);
        run_frame(4, 1'b0);
        expect_out(0, 1984, 992, -992);
        set_fm(-1000, 1000, -1000, 1000);
        run_frame(4, 1'b0);
        expect_out(0, -1985, -993, 992);

        // large L-R saturates
        set_fm(127000, -127000, 127000, -127000);
        run_frame(4, 1'b0);
        expect_out(0, 131071, 65535, -65536);

        // full-scale negative inputs
        set_fm(-524288, -524288, -524288, -524288);
        set_fc(-128, -128, -128, -128);
        run_frame(4, 1'b0);
        expect_out(-131072, 131071, -1, -131072);

        // floor on the sum path
        set_fm(-1, -1, -1, -2);
        set_fc(0, 0, 0, 0);
        run_frame(4, 1'b0);
        expect_out(-2, 0, -1, -1);

        // slips: 3-sample frame, then 5-sample frame
        set_fm(4000, 4000, 4000, 4000);
        run_frame(4, 1'b0);
        expect_out(4000, 0, 2000, 2000);
        run_frame(3, 1'b0);
        run_frame(4, 1'b0);
        @(negedge clock);
        chk("slip_after_short", int'(slip_count), 1);
        expect_out(4000, 0, 2000, 2000);
        run_frame(5, 1'b0);
        run_frame(4, 1'b0);
        @(negedge clock);
        chk("slip_after_long", int'(slip_count), 2);
        expect_out(4000, 0, 2000, 2000);

        // coincident strobes: first sample belongs to the new frame
        set_fm(400, 800, 1200, 1600);
        repeat (3) begin
            run_frame(4, 1'b1);
            expect_out(1000, 0, 500, 500);
        end

        // reset mid-frame after two samples, with strobes on the reset cycle
        cyc(1'b1, 1'b0, '0, '0);
        cyc(1'b0, 1'b0, '0, '0);
        cyc(1'b0, 1'b1, 20'sd4000, 8'sd0);
        cyc(1'b0, 1'b0, '0, '0);
        cyc(1'b0, 1'b1, 20'sd4000, 8'sd0);
        cyc(1'b0, 1'b0, '0, '0);
        chk("slip_coincident", int'(slip_count), 2);
        reset = 1'b1;
        cyc(1'b1, 1'b1, 20'sd4000, 8'sd0);
        reset = 1'b0;
        @(negedge clock);
        chk("midrst_locked", int'(locked), 0);
        chk("midrst_slip",   int'(slip_count), 0);
        chk("midrst_LpR",    int'(LpR_est), 0);
        chk("midrst_LEFT",   int'(LEFTout), 0);

        set_fm(4000, 4000, 4000, 4000);
        set_fc(0, 0, 0, 0);
        run_frame(4, 1'b0);
        expect_out(4000, 0, 2000, 2000);
        run_frame(4, 1'b0);
        expect_out(4000, 0, 2000, 2000);
        cyc(1'b1, 1'b0, '0, '0);
        repeat (6) cyc(1'b0, 1'b0, '0, '0);
        chk("outputs_outstanding", q.size(), 0);
        chk("final_slip", int'(slip_count), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
